// File: rtl/bank_port_arbiter_pkg.sv
// Shared definitions for the feature-memory bank port arbiter.
// Build option: BANK_ARB_FIXED_PRIO_EN selects fixed-priority arbitration.
package bank_arb_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        DRAIN   = 2'd1,
        SPI_OWN = 2'd2
    } state_e;

    // Stages between a read grant and its rd_valid pulse
    localparam int unsigned TAG_DEPTH = 2;

    // Width of a requester index; never narrower than one bit
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bank_port_arbiter_rr_arbiter.sv
// One-hot request arbiter with index output.
// Default: round-robin with its own pointer (constant 0 when N == 1).
// BANK_ARB_FIXED_PRIO_EN: fixed priority, index 0 highest, no pointer.
module rr_arbiter
    import bank_arb_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req_i,
    input  logic          enable_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic [IW-1:0] start;
    logic          found;

    // Pick the first requester at or after the search start, wrapping around
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        if (enable_i) begin
            for (int unsigned i = 0; i < N; i++) begin
                for (int unsigned j = 0; j < N; j++) begin
                    if (!found && req_i[j] && ((32'(start) + i) % N == j)) begin
                        found        = 1'b1;
                        gnt_o[j]     = 1'b1;
                        gnt_idx_o    = IW'(j);
                    end
                end
            end
        end
    end

`ifdef BANK_ARB_FIXED_PRIO_EN
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign start = '0;
`else
    if (N > 1) begin : g_ptr
        logic [IW-1:0] ptr_q, ptr_d;

        // Advance past the winner; hold when nothing is granted
        always_comb begin
            ptr_d = ptr_q;
            if (|gnt_o) begin
                ptr_d = (gnt_idx_o == IW'(N - 1)) ? '0 : gnt_idx_o + 1'b1;
            end
        end

        // Pointer register
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ptr_q <= '0;
            else        ptr_q <= ptr_d;
        end

        assign start = ptr_q;
    end else begin : g_no_ptr
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst_n;
        assign start = '0;
    end
`endif

endmodule

// File: rtl/bank_port_arbiter.sv
// Shares one dual-port feature bank between read requesters (port A) and
// write requesters (port B), with an SPI-loader ownership hand-off.
// Build option: BANK_ARB_FIXED_PRIO_EN (fixed priority in both arbiters).
module bank_port_arbiter
    import bank_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_RD     = 3,
    parameter int unsigned NUM_WR     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         spi_req,
    output logic                         spi_ack,
    input  logic [NUM_RD-1:0]            rd_req,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_RD-1:0]            rd_gnt,
    output logic [NUM_RD-1:0]            rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    input  logic [NUM_WR-1:0]            wr_req,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_WR-1:0]            wr_gnt,
    output logic                         mem_csen,
    output logic                         mem_rdena,
    output logic [ADDR_WIDTH-1:0]        mem_addr_a,
    input  logic [DATA_WIDTH-1:0]        mem_data_a,
    output logic                         mem_wrenb,
    output logic [ADDR_WIDTH-1:0]        mem_addr_b,
    output logic [DATA_WIDTH-1:0]        mem_data_b
);

    localparam int unsigned RIW = idx_width(NUM_RD);
    localparam int unsigned WIW = idx_width(NUM_WR);

    typedef struct packed {
        logic           vld;
        logic [RIW-1:0] idx;
    } tag_t;

    state_e                  state_q, state_d;
    tag_t                    tag_q [TAG_DEPTH];
    tag_t                    tag_d;
    logic                    grant_en;
    logic                    pipe_empty;
    logic [RIW-1:0]          rd_idx;
    logic [WIW-1:0]          wr_idx;
    logic [ADDR_WIDTH-1:0]   rd_addr_sel, wr_addr_sel;
    logic [DATA_WIDTH-1:0]   wr_data_sel;
    logic                    rdena_q, wrenb_q;
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_b_q;
    logic [DATA_WIDTH-1:0]   data_b_q;

    // Grants are also held off while reset is asserted so every output reads 0
    assign grant_en = rst_n && (state_q == RUN) && !spi_req;

    rr_arbiter #(.N(NUM_RD)) u_rd_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (rd_req),
        .enable_i  (grant_en),
        .gnt_o     (rd_gnt),
        .gnt_idx_o (rd_idx)
    );

    rr_arbiter #(.N(NUM_WR)) u_wr_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (wr_req),
        .enable_i  (grant_en),
        .gnt_o     (wr_gnt),
        .gnt_idx_o (wr_idx)
    );

    // Route the winning requester's address/data; zero when nobody wins
    always_comb begin
        rd_addr_sel = '0;
        wr_addr_sel = '0;
        wr_data_sel = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            if (|rd_gnt && rd_idx == RIW'(i)) rd_addr_sel = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        end
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (|wr_gnt && wr_idx == WIW'(i)) begin
                wr_addr_sel = wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                wr_data_sel = wr_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Bank command registers: one cycle after the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdena_q  <= 1'b0;
            addr_a_q <= '0;
            wrenb_q  <= 1'b0;
            addr_b_q <= '0;
            data_b_q <= '0;
        end else begin
            rdena_q  <= |rd_gnt;
            addr_a_q <= rd_addr_sel;
            wrenb_q  <= |wr_gnt;
            addr_b_q <= wr_addr_sel;
            data_b_q <= wr_data_sel;
        end
    end

    assign tag_d = '{vld: |rd_gnt, idx: rd_idx};

    // Read tag pipeline: follows each read to the cycle its data returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < TAG_DEPTH; i++) tag_q[i] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int unsigned i = 1; i < TAG_DEPTH; i++) tag_q[i] <= tag_q[i-1];
        end
    end

    // Valid pulse and data for the read whose tag reached the last stage
    always_comb begin
        pipe_empty = 1'b1;
        for (int unsigned i = 0; i < TAG_DEPTH; i++) begin
            if (tag_q[i].vld) pipe_empty = 1'b0;
        end
        rd_valid = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_valid[i] = tag_q[TAG_DEPTH-1].vld && (tag_q[TAG_DEPTH-1].idx == RIW'(i));
        end
        rd_data = tag_q[TAG_DEPTH-1].vld ? mem_data_a : '0;
    end

    // Ownership state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= RUN;
        else        state_q <= state_d;
    end

    // Ownership transitions: drain outstanding reads before handing the bank over
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (spi_req) state_d = DRAIN;
            DRAIN:   if (pipe_empty) state_d = spi_req ? SPI_OWN : RUN;
            SPI_OWN: if (!spi_req) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign spi_ack    = (state_q == SPI_OWN) && spi_req;
    assign mem_rdena  = rdena_q;
    assign mem_addr_a = addr_a_q;
    assign mem_wrenb  = wrenb_q;
    assign mem_addr_b = addr_b_q;
    assign mem_data_b = data_b_q;
    assign mem_csen   = rdena_q | wrenb_q;

endmodule
